seven_segment_controller: RTL

SEVEN_SEGMENT_CONTROLLER -- requirements
Module: seven_segment_controller

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/bto7s.sv | 30 +++
 rtl/seven_segment_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks.
// Digit count, the all-off cathode pattern, the dash code and the digit index type
// live here so every block that touches a display agrees on them.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    // All cathodes released (active-low), i.e. the digit is dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Nibble code that renders a single centre bar (segment g).
    localparam logic [3:0] DASH_CODE = 4'hA;

    typedef logic [2:0] digit_idx_t;

    // Select the 4-bit code for digit i out of a packed 8-digit value.
    function automatic logic [3:0] nibble_at(input logic [31:0] v, input digit_idx_t i);
        logic [4:0] base;
        base = {i, 2'b00};
        return v[base +: 4];
    endfunction

    // Shift amount that drops every nibble below digit i.
    function automatic logic [4:0] nibble_shift(input digit_idx_t i);
        return {i, 2'b00};
    endfunction

endpackage

// File: rtl/bto7s.sv
// Binary-to-seven-segment decoder.
// Output is active-high, bit 0 = segment a ... bit 6 = segment g.
// 0x0-0x9 are numerals, the dash code lights segment g only, everything else is dark.
module bto7s
    import seg7_pkg::*;
(
    input  logic [3:0] x_in,
    output logic [6:0] s_out
);

    // Pure lookup; callers do any polarity inversion they need.
    always_comb begin
        s_out = 7'b0000000;
        unique case (x_in)
            4'h0:    s_out = 7'b0111111;
            4'h1:    s_out = 7'b0000110;
            4'h2:    s_out = 7'b1011011;
            4'h3:    s_out = 7'b1001111;
            4'h4:    s_out = 7'b1100110;
            4'h5:    s_out = 7'b1101101;
            4'h6:    s_out = 7'b1111101;
            4'h7:    s_out = 7'b0000111;
            4'h8:    s_out = 7'b1111111;
            4'h9:    s_out = 7'b1101111;
            DASH_CODE: s_out = 7'b1000000;
            default: s_out = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seven_segment_controller.sv
// Eight-digit multiplexed seven-segment controller.
// Scans one digit per COUNT_PERIOD cycles, blanks the anodes for the first
// BLANK_CYCLES of each slot to avoid ghosting, and double-buffers the displayed
// value so a new value only takes effect at the end of a full frame (digit 7 done).
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits.
//
// Handshake: val_valid_in is a single-cycle strobe with no back-pressure; every
// strobe outside reset is accepted and the most recent one before the frame
// boundary is the one that gets displayed.
module seven_segment_controller
    import seg7_pkg::*;
#(
    parameter int COUNT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] val_in,
    input  logic        val_valid_in,
    output logic        update_pending_out,
    output logic [6:0]  cat_out,
    output logic [7:0]  an_out
);

    localparam int CNT_W = (COUNT_PERIOD > 2) ? $clog2(COUNT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    logic [31:0]      pending_reg;
    logic [31:0]      display_reg;

    logic             slot_end;
    logic             frame_end;
    logic             in_blank;
    logic [3:0]       cur_code;
    logic [6:0]       seg_on;
    logic [6:0]       cat_next;
    logic [7:0]       an_next;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == digit_idx_t'(NUM_DIGITS - 1));

    // A zero-length blanking window would make the comparison constant, so it is
    // resolved at elaboration instead.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
            assign in_blank = (cnt < BLANK_C);
        end
    endgenerate

    assign cur_code = nibble_at(display_reg, idx);

    bto7s u_dec (
        .x_in  (cur_code),
        .s_out (seg_on)
    );

    // Next cathode pattern: invert the decoder to active-low, optionally darkening
    // digits whose own nibble and all higher nibbles are zero (digit 0 always shows).
    always_comb begin
        cat_next = ~seg_on;
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx != digit_idx_t'(0)) && ((display_reg >> nibble_shift(idx)) == 32'h0)) begin
            cat_next = SEG_OFF;
        end
`endif
    end

    // Next anode pattern: exactly one digit low outside the blanking window.
    always_comb begin
        an_next = 8'hFF;
        if (!in_blank) begin
            an_next = ~(8'b0000_0001 << idx);
        end
    end

    // Scan counters: cnt sweeps one slot, idx advances at each slot end and wraps.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + digit_idx_t'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Double buffer: strobes land in pending_reg; display_reg only changes at the
    // frame boundary. A strobe on the boundary itself goes straight to display.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending_reg        <= '0;
            display_reg        <= '0;
            update_pending_out <= 1'b0;
        end else if (val_valid_in && frame_end) begin
            pending_reg        <= val_in;
            display_reg        <= val_in;
            update_pending_out <= 1'b0;
        end else if (val_valid_in) begin
            pending_reg        <= val_in;
            update_pending_out <= 1'b1;
        end else if (frame_end && update_pending_out) begin
            display_reg        <= pending_reg;
            update_pending_out <= 1'b0;
        end
    end

    // Registered drive pins, one cycle behind the scan state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            an_out  <= 8'hFF;
            cat_out <= SEG_OFF;
        end else begin
            an_out  <= an_next;
            cat_out <= cat_next;
        end
    end

endmodule
